// File: rtl/rob_retire_unit_pkg.sv
// Shared sizing defaults for the ROB retirement/allocation engine.
package rob_retire_unit_pkg;
  localparam int ROB_NUM_DEF     = 64;
  localparam int ROB_SEL_DEF     = 6;
  localparam int ROB_IDX_NUM_DEF = 2;
endpackage

// File: rtl/rob_retire_unit_retire_select.sv
// Combinational head-of-ROB retire selection; the second slot exists only when
// RETIRE_DUAL_EN is defined.
module retire_select
  import rob_retire_unit_pkg::*;
#(
  parameter int ROB_NUM = ROB_NUM_DEF,
  parameter int ROB_SEL = ROB_SEL_DEF
) (
  input  logic [ROB_SEL-1:0] head,
  input  logic [ROB_NUM-1:0] valid,
  input  logic [ROB_NUM-1:0] done,
  output logic               r1,
  output logic               r2,
  output logic [ROB_SEL-1:0] idx_1,
  output logic [ROB_SEL-1:0] idx_2
);
  always_comb begin
    idx_1 = head;
    r1    = valid[head] & done[head];
`ifdef RETIRE_DUAL_EN
    idx_2 = head + ROB_SEL'(1);
    r2    = r1 & valid[idx_2] & done[idx_2];
`else
    idx_2 = '0;
    r2    = 1'b0;
`endif
  end
endmodule

// File: rtl/rob_retire_unit.sv
// ROB index allocator and in-order retirement engine with violation flush.
// RETIRE_DUAL_EN: when defined, up to two entries retire per cycle.
module rob_retire_unit
  import rob_retire_unit_pkg::*;
#(
  parameter int ROB_NUM = ROB_NUM_DEF,
  parameter int ROB_SEL = ROB_SEL_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               alloc_valid_1,
  input  logic               alloc_valid_2,
  output logic [ROB_SEL-1:0] alloc_idx_1,
  output logic [ROB_SEL-1:0] alloc_idx_2,
  output logic               alloc_ready,
  input  logic               wb_valid_1,
  input  logic               wb_valid_2,
  input  logic [ROB_SEL-1:0] wb_idx_1,
  input  logic [ROB_SEL-1:0] wb_idx_2,
  input  logic               violation_detected,
  output logic               commit_enable_1,
  output logic               commit_enable_2,
  output logic [ROB_SEL-1:0] commit_rob_idx_1,
  output logic [ROB_SEL-1:0] commit_rob_idx_2,
  output logic               rob_full,
  output logic               rob_empty,
  output logic [ROB_SEL:0]   rob_count
);
  logic [ROB_NUM-1:0] valid_q, valid_d;
  logic [ROB_NUM-1:0] done_q, done_d;
  logic [ROB_SEL-1:0] head_q, tail_q, slot2_idx;
  logic [ROB_SEL:0]   count_q;
  logic               cen1_q, cen2_q;
  logic [ROB_SEL-1:0] cidx1_q, cidx2_q;
  logic               r1, r2;
  logic [ROB_SEL-1:0] ret_idx_1, ret_idx_2;
  logic [1:0]         alloc_n, ret_n;

  retire_select #(.ROB_NUM(ROB_NUM), .ROB_SEL(ROB_SEL)) u_sel (
    .head  (head_q),
    .valid (valid_q),
    .done  (done_q),
    .r1    (r1),
    .r2    (r2),
    .idx_1 (ret_idx_1),
    .idx_2 (ret_idx_2)
  );

  assign alloc_ready = (count_q <= (ROB_SEL+1)'(ROB_NUM - 2));
  // Requests arriving while not ready are dropped entirely.
  assign alloc_n     = alloc_ready ? ({1'b0, alloc_valid_1} + {1'b0, alloc_valid_2}) : 2'd0;
  assign ret_n       = {1'b0, r1} + {1'b0, r2};
  assign slot2_idx   = tail_q + ROB_SEL'(1);

  generate
    for (genvar gi = 0; gi < ROB_NUM; gi++) begin : g_entry
      logic hit_alloc, hit_ret, hit_wb;
      assign hit_alloc = ((alloc_n != 2'd0) && (tail_q == ROB_SEL'(gi))) ||
                         ((alloc_n == 2'd2) && (slot2_idx == ROB_SEL'(gi)));
      assign hit_ret   = (r1 && (ret_idx_1 == ROB_SEL'(gi))) ||
                         (r2 && (ret_idx_2 == ROB_SEL'(gi)));
      assign hit_wb    = (wb_valid_1 && (wb_idx_1 == ROB_SEL'(gi))) ||
                         (wb_valid_2 && (wb_idx_2 == ROB_SEL'(gi)));
      // Writeback to an entry retiring this cycle is harmless: the retire clear wins.
      assign valid_d[gi] = hit_alloc ? 1'b1 : (hit_ret ? 1'b0 : valid_q[gi]);
      assign done_d[gi]  = (hit_alloc || hit_ret) ? 1'b0 : (done_q[gi] | (hit_wb & valid_q[gi]));
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      done_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      cen1_q  <= 1'b0;
      cen2_q  <= 1'b0;
      cidx1_q <= '0;
      cidx2_q <= '0;
    end else if (violation_detected) begin
      valid_q <= '0;
      done_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      cen1_q  <= 1'b0;
      cen2_q  <= 1'b0;
      cidx1_q <= '0;
      cidx2_q <= '0;
    end else begin
      valid_q <= valid_d;
      done_q  <= done_d;
      head_q  <= head_q + ROB_SEL'(ret_n);
      tail_q  <= tail_q + ROB_SEL'(alloc_n);
      count_q <= count_q + (ROB_SEL+1)'(alloc_n) - (ROB_SEL+1)'(ret_n);
      cen1_q  <= r1;
      cen2_q  <= r2;
      cidx1_q <= r1 ? ret_idx_1 : '0;
      cidx2_q <= r2 ? ret_idx_2 : '0;
    end
  end

  assign alloc_idx_1      = tail_q;
  assign alloc_idx_2      = slot2_idx;
  assign commit_enable_1  = cen1_q;
  assign commit_enable_2  = cen2_q;
  assign commit_rob_idx_1 = cidx1_q;
  assign commit_rob_idx_2 = cidx2_q;
  assign rob_full         = (count_q == (ROB_SEL+1)'(ROB_NUM));
  assign rob_empty        = (count_q == '0);
  assign rob_count        = count_q;
endmodule

// File: tb/tb_rob_retire_unit.sv
// Randomized + directed scoreboard bench for rob_retire_unit against a
// queue-based model of the in-flight program-order window.
module tb_rob_retire_unit;
  localparam int N = 64;
`ifdef RETIRE_DUAL_EN
  localparam int MAXR = 2;
`else
  localparam int MAXR = 1;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       alloc_valid_1 = 0, alloc_valid_2 = 0;
  logic [5:0] alloc_idx_1, alloc_idx_2;
  logic       alloc_ready;
  logic       wb_valid_1 = 0, wb_valid_2 = 0;
  logic [5:0] wb_idx_1 = '0, wb_idx_2 = '0;
  logic       violation_detected = 0;
  logic       commit_enable_1, commit_enable_2;
  logic [5:0] commit_rob_idx_1, commit_rob_idx_2;
  logic       rob_full, rob_empty;
  logic [6:0] rob_count;

  rob_retire_unit dut (
    .clk(clk), .reset(reset),
    .alloc_valid_1(alloc_valid_1), .alloc_valid_2(alloc_valid_2),
    .alloc_idx_1(alloc_idx_1), .alloc_idx_2(alloc_idx_2), .alloc_ready(alloc_ready),
    .wb_valid_1(wb_valid_1), .wb_valid_2(wb_valid_2),
    .wb_idx_1(wb_idx_1), .wb_idx_2(wb_idx_2),
    .violation_detected(violation_detected),
    .commit_enable_1(commit_enable_1), .commit_enable_2(commit_enable_2),
    .commit_rob_idx_1(commit_rob_idx_1), .commit_rob_idx_2(commit_rob_idx_2),
    .rob_full(rob_full), .rob_empty(rob_empty), .rob_count(rob_count)
  );

  always #5 clk = ~clk;

  typedef struct {bit e1; int i1; bit e2; int i2;} rec_t;
  rec_t exp_q[$];
  int   mq[$];          // in-flight indices, oldest first
  bit   v_m[N];
  bit   d_m[N];
  int   m_tail;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    for (int i = 0; i < N; i++) begin v_m[i] = 0; d_m[i] = 0; end
    m_tail = 0;
  endtask

  task automatic check_status();
    int sz;
    sz = mq.size();
    chk("rob_count", int'(rob_count), sz);
    chk("rob_empty", int'(rob_empty), int'(sz == 0));
    chk("rob_full", int'(rob_full), int'(sz == N));
    chk("alloc_ready", int'(alloc_ready), int'(N - sz >= 2));
    chk("alloc_idx_1", int'(alloc_idx_1), m_tail);
    chk("alloc_idx_2", int'(alloc_idx_2), (m_tail + 1) % N);
  endtask

  // Drive one cycle of inputs, advance the model, then check status after the edge.
  task automatic step(input bit a1, input bit a2, input bit w1v, input int w1i,
                      input bit w2v, input int w2i, input bit viol);
    int size0, k, idx;
    rec_t r;
    alloc_valid_1 = a1; alloc_valid_2 = a2;
    wb_valid_1 = w1v; wb_idx_1 = 6'(w1i);
    wb_valid_2 = w2v; wb_idx_2 = 6'(w2i);
    violation_detected = viol;
    size0 = mq.size();
    if (viol) model_clear();
    else begin
      r = '{0, 0, 0, 0};
      k = 0;
      while (k < MAXR && mq.size() > 0 && d_m[mq[0]]) begin
        idx = mq.pop_front();
        v_m[idx] = 0; d_m[idx] = 0;
        if (k == 0) begin r.e1 = 1; r.i1 = idx; end
        else        begin r.e2 = 1; r.i2 = idx; end
        k++;
      end
      if (k > 0) exp_q.push_back(r);
      if (w1v && v_m[w1i]) d_m[w1i] = 1;
      if (w2v && v_m[w2i]) d_m[w2i] = 1;
      if (N - size0 >= 2) begin
        if (a1) begin mq.push_back(m_tail); v_m[m_tail] = 1; d_m[m_tail] = 0; m_tail = (m_tail + 1) % N; end
        if (a2) begin mq.push_back(m_tail); v_m[m_tail] = 1; d_m[m_tail] = 0; m_tail = (m_tail + 1) % N; end
      end
    end
    @(posedge clk);
    #1;
    check_status();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic pick_wb(output bit v, output int idx);
    if (mq.size() > 0 && $urandom_range(0, 3) != 0) begin
      v = 1; idx = mq[$urandom_range(0, mq.size() - 1)];
    end else begin
      v = $urandom_range(0, 1); idx = $urandom_range(0, N - 1);
    end
  endtask

  task automatic mid_reset();
    reset = 1;
    alloc_valid_1 = 0; alloc_valid_2 = 0; wb_valid_1 = 0; wb_valid_2 = 0; violation_detected = 0;
    #1;
    model_clear();
    exp_q.delete();
    check_status();
    chk("rst_commit_enable_1", int'(commit_enable_1), 0);
    chk("rst_commit_enable_2", int'(commit_enable_2), 0);
    #1 reset = 0;
    $display("txn: asynchronous reset mid-operation");
  endtask

  // Monitor: every commit strobe must match the oldest pending expected record.
  always @(negedge clk) begin
    if (!reset) begin
      if (commit_enable_1 || commit_enable_2) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_commit", 1, 0);
        end else begin
          rec_t r;
          r = exp_q.pop_front();
          chk("commit_enable_1", int'(commit_enable_1), int'(r.e1));
          chk("commit_rob_idx_1", int'(commit_rob_idx_1), r.i1);
          chk("commit_enable_2", int'(commit_enable_2), int'(r.e2));
          chk("commit_rob_idx_2", int'(commit_rob_idx_2), r.i2);
          $display("txn: commit e1=%0d i1=%0d e2=%0d i2=%0d", commit_enable_1, commit_rob_idx_1,
                   commit_enable_2, commit_rob_idx_2);
        end
      end else begin
        chk("idle_commit_idx_1", int'(commit_rob_idx_1), 0);
        chk("idle_commit_idx_2", int'(commit_rob_idx_2), 0);
      end
    end
  end

  initial begin
    bit w1v, w2v;
    int w1i, w2i;
    model_clear();
    #12;
    check_status();
    chk("reset_commit_enable_1", int'(commit_enable_1), 0);
    chk("reset_commit_enable_2", int'(commit_enable_2), 0);
    chk("reset_commit_idx_1", int'(commit_rob_idx_1), 0);
    chk("reset_commit_idx_2", int'(commit_rob_idx_2), 0);
    reset = 0;
    @(posedge clk); #1;
    $display("txn: reset checked");

    // Out-of-order completion, in-order retire.
    step(1, 1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    idle(4);
    $display("txn: ooo writeback pair done");

    // Fill to full, then an extra alloc is ignored.
    for (int i = 0; i < 32; i++) step(1, 1, 0, 0, 0, 0, 0);
    chk("full_flag", int'(rob_full), 1);
    step(1, 1, 0, 0, 0, 0, 0);
    chk("full_count_hold", int'(rob_count), 64);
    step(0, 0, 0, 0, 0, 0, 1);
    $display("txn: fill to full and flush");

    // Move head/tail to 62, then allocate across the wrap.
    for (int i = 0; i < 31; i++) step(1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 31; i++) step(0, 0, 1, 2 * i, 1, 2 * i + 1, 0);
    idle(70);
    chk("wrap_tail", int'(alloc_idx_1), 62);
    step(1, 1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 62, 1, 63, 0);
    step(0, 0, 1, 0, 1, 1, 0);
    idle(5);
    $display("txn: wrap-around retire");

    // Flush with done entries sitting at the head.
    step(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 1, 2, 0);
    step(0, 0, 1, 3, 1, 0, 0);
    step(0, 0, 1, 4, 0, 0, 1);
    chk("flush_count", int'(rob_count), 0);
    idle(3);
    $display("txn: violation flush");

    // Randomized traffic.
    for (int it = 0; it < 1500; it++) begin
      pick_wb(w1v, w1i);
      pick_wb(w2v, w2i);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, w1v, w1i, w2v, w2i,
           $urandom_range(0, 299) == 0);
      if (it == 700) mid_reset();
    end
    $display("txn: random traffic done");

    // Drain any pending completions.
    for (int i = 0; i < 70; i++) begin
      if (mq.size() > 0) step(0, 0, 1, mq[0], mq.size() > 1, (mq.size() > 1) ? mq[1] : 0, 0);
      else idle(1);
    end
    idle(3);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
